// File: rtl/acc_pkg.sv
// Shared types and constants for the accumulator datapath and its input FIFO.
package acc_pkg;

    localparam int DATA_W = 8;
    localparam int SUM_W  = 16;

    typedef logic [DATA_W-1:0] byte_t;
    typedef logic [SUM_W-1:0]  sum_t;

    // Zero-extend a byte and add it to a running sum (wraps at SUM_W bits).
    function automatic sum_t sum_add(input sum_t acc, input byte_t b);
        return acc + sum_t'(b);
    endfunction

endpackage

// File: rtl/acc_fifo_mem.sv
// Storage array for the accumulator input FIFO: one write port, one read port
// addressed by the (registered) read pointer. Contents are not reset; the
// pointers alone define which entries are valid.
module acc_fifo_mem #(
    parameter  int DEPTH  = 16,
    parameter  int DATA_W = 8,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en_i,
    input  logic [AW-1:0]     wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic [AW-1:0]     rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Write the accepted byte into the entry selected by the write pointer.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/acc_input_fifo.sv
// Byte FIFO feeding the accumulator. The accumulator adds its input on every
// clock, so data_out is forced to zero on any cycle without a popped byte.
module acc_input_fifo #(
    parameter  int DEPTH  = 16,
    parameter  int DATA_W = acc_pkg::DATA_W,
    localparam int AW     = $clog2(DEPTH),
    localparam int PW     = AW + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic              drain_en,
    input  logic              flush,
    output logic [DATA_W-1:0] data_out,
    output logic              data_out_valid,
    output logic [PW-1:0]     level,
    output logic              empty,
    output logic              full
);

    import acc_pkg::*;

    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              data_out_valid_q, data_out_valid_d;
    logic              in_ready_q, in_ready_d;

    logic [PW-1:0]     level_s;
    logic [PW-1:0]     level_next_s;
    logic              empty_s;
    logic              full_s;
    logic              push_s;
    logic              pop_s;
    logic [DATA_W-1:0] rd_data_s;

    // Occupancy and flags follow directly from the extra-MSB pointer scheme.
    assign level_s = wr_ptr_q - rd_ptr_q;
    assign empty_s = (wr_ptr_q == rd_ptr_q);
    assign full_s  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    acc_fifo_mem #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_mem (
        .clk       (clk),
        .wr_en_i   (push_s),
        .wr_addr_i (wr_ptr_q[AW-1:0]),
        .wr_data_i (in_data),
        .rd_addr_i (rd_ptr_q[AW-1:0]),
        .rd_data_o (rd_data_s)
    );

    // Next-state: flush wins; otherwise push/pop from registered flags only,
    // and in_ready is derived from the post-update occupancy.
    always_comb begin
        wr_ptr_d         = wr_ptr_q;
        rd_ptr_d         = rd_ptr_q;
        data_out_d       = '0;
        data_out_valid_d = 1'b0;
        push_s           = 1'b0;
        pop_s            = 1'b0;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            push_s = in_valid && in_ready_q && !full_s;
            pop_s  = drain_en && !empty_s;
            if (push_s) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d         = rd_ptr_q + PW'(1);
                data_out_d       = rd_data_s;
                data_out_valid_d = 1'b1;
            end else begin
                rd_ptr_d         = rd_ptr_q;
                data_out_d       = '0;
                data_out_valid_d = 1'b0;
            end
        end
        level_next_s = wr_ptr_d - rd_ptr_d;
        if (flush) begin
            in_ready_d = 1'b1;
        end else begin
            in_ready_d = (level_next_s < PW'(DEPTH));
        end
    end

    // State register; async reset leaves in_ready low until the first clean edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q         <= '0;
            rd_ptr_q         <= '0;
            data_out_q       <= '0;
            data_out_valid_q <= 1'b0;
            in_ready_q       <= 1'b0;
        end else begin
            wr_ptr_q         <= wr_ptr_d;
            rd_ptr_q         <= rd_ptr_d;
            data_out_q       <= data_out_d;
            data_out_valid_q <= data_out_valid_d;
            in_ready_q       <= in_ready_d;
        end
    end

    assign in_ready       = in_ready_q;
    assign data_out       = data_out_q;
    assign data_out_valid = data_out_valid_q;
    assign level          = level_s;
    assign empty          = empty_s;
    assign full           = full_s;

endmodule

// File: tb/tb_acc_input_fifo.sv
// Self-checking bench for acc_input_fifo: queue-based reference model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_acc_input_fifo;

    localparam int DEPTH = 16;
    localparam int DW    = 8;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          drain_en;
    logic          flush;
    logic [DW-1:0] data_out;
    logic          data_out_valid;
    logic [LW-1:0] level;
    logic          empty;
    logic          full;

    acc_input_fifo #(.DEPTH(DEPTH), .DATA_W(DW)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_data        (in_data),
        .in_ready       (in_ready),
        .drain_en       (drain_en),
        .flush          (flush),
        .data_out       (data_out),
        .data_out_valid (data_out_valid),
        .level          (level),
        .empty          (empty),
        .full           (full)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [DW-1:0] m_q[$];
    logic          m_ready;
    logic [DW-1:0] m_dout;
    logic          m_dv;
    logic [15:0]   acc_sum;      // what an accumulator fed by data_out holds
    logic [15:0]   accepted_sum; // sum of bytes the model accepted

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_ready = 1'b0;
        m_dout  = '0;
        m_dv    = 1'b0;
    endtask

    task automatic check_all();
        chk("in_ready", {31'd0, in_ready}, {31'd0, m_ready});
        chk("data_out", {24'd0, data_out}, {24'd0, m_dout});
        chk("data_out_valid", {31'd0, data_out_valid}, {31'd0, m_dv});
        chk("level", {27'd0, level}, m_q.size());
        chk("empty", {31'd0, empty}, {31'd0, (m_q.size() == 0)});
        chk("full", {31'd0, full}, {31'd0, (m_q.size() == DEPTH)});
    endtask

    // One clock: advance the model from current inputs, take the edge, compare.
    task automatic step();
        logic do_pop;
        logic do_push;
        if (rst) begin
            model_reset();
        end else if (flush) begin
            m_q.delete();
            m_dout  = '0;
            m_dv    = 1'b0;
            m_ready = 1'b1;
        end else begin
            do_pop  = drain_en && (m_q.size() > 0);
            do_push = in_valid && m_ready;
            if (do_pop) begin
                m_dout = m_q.pop_front();
                m_dv   = 1'b1;
            end else begin
                m_dout = '0;
                m_dv   = 1'b0;
            end
            if (do_push) begin
                m_q.push_back(in_data);
                accepted_sum = accepted_sum + 16'(in_data);
            end
            m_ready = (m_q.size() < DEPTH);
        end
        @(posedge clk);
        #1;
        acc_sum = acc_sum + 16'(data_out);
        check_all();
    endtask

    logic [15:0] sum_start;

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; drain_en = 1'b0; flush = 1'b0;
        acc_sum = '0; accepted_sum = '0;
        model_reset();
        #1;
        check_all();
        // Reset then idle
        step(); step();
        chk("rst_level", {27'd0, level}, 32'd0);
        chk("rst_ready", {31'd0, in_ready}, 32'd0);
        rst = 1'b0;
        acc_sum = '0;
        step();
        chk("ready_first_edge", {31'd0, in_ready}, 32'd1);
        for (int i = 0; i < 4; i++) step();
        chk("idle_empty", {31'd0, empty}, 32'd1);

        // Single byte latency
        sum_start = acc_sum;
        drain_en = 1'b1; in_valid = 1'b1; in_data = 8'hA5;
        step();
        in_valid = 1'b0;
        chk("lat_edgeN_dv", {31'd0, data_out_valid}, 32'd0);
        step();
        chk("lat_dout", {24'd0, data_out}, 32'h0000_00A5);
        chk("lat_dv", {31'd0, data_out_valid}, 32'd1);
        step();
        chk("lat_dout_clear", {24'd0, data_out}, 32'd0);
        chk("lat_sum", {16'd0, acc_sum - sum_start}, 32'h0000_00A5);

        // Fill with drain off
        drain_en = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            in_valid = 1'b1; in_data = 8'(i);
            step();
        end
        chk("fill_full", {31'd0, full}, 32'd1);
        chk("fill_level", {27'd0, level}, 32'd16);
        chk("fill_ready", {31'd0, in_ready}, 32'd0);
        in_data = 8'hFF;
        step();
        chk("held_off_level", {27'd0, level}, 32'd16);
        in_valid = 1'b0; drain_en = 1'b1;
        sum_start = acc_sum;
        for (int i = 1; i <= 16; i++) begin
            step();
            chk("drain_order", {24'd0, data_out}, 32'(i));
        end
        step();
        chk("drain_sum", {16'd0, acc_sum - sum_start}, 32'h0000_0088);

        // Simultaneous push/pop at level 3
        drain_en = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin in_data = 8'(8'h30 + i); step(); end
        drain_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_data = 8'(8'h40 + i);
            step();
            chk("pp_level", {27'd0, level}, 32'd3);
        end
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) step();

        // Flush mid-stream with a byte offered
        drain_en = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin in_data = 8'(8'h50 + i); step(); end
        chk("pre_flush_level", {27'd0, level}, 32'd5);
        flush = 1'b1; in_data = 8'h77;
        step();
        chk("flush_level", {27'd0, level}, 32'd0);
        chk("flush_dv", {31'd0, data_out_valid}, 32'd0);
        chk("flush_ready", {31'd0, in_ready}, 32'd1);
        flush = 1'b0; in_valid = 1'b0; drain_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("no_77", {31'd0, data_out_valid}, 32'd0);
        end

        // Randomized traffic, with occasional flushes
        for (int i = 0; i < 400; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_data  = 8'($urandom);
            drain_en = ($urandom_range(0, 3) != 0);
            flush    = ($urandom_range(0, 49) == 0);
            step();
        end
        // Flush, then random traffic without flush and check the sum relation
        flush = 1'b1; in_valid = 1'b0;
        step();
        flush = 1'b0;
        sum_start = acc_sum; accepted_sum = '0;
        for (int i = 0; i < 300; i++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_data  = 8'($urandom);
            drain_en = 1'($urandom_range(0, 1));
            step();
        end
        in_valid = 1'b0; drain_en = 1'b1;
        for (int i = 0; i < DEPTH + 2; i++) step();
        chk("sum_relation", {16'd0, acc_sum - sum_start}, {16'd0, accepted_sum});

        // Async reset mid-drain at level 7
        drain_en = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin in_data = 8'(8'h60 + i); step(); end
        in_valid = 1'b0; drain_en = 1'b1;
        step();
        chk("pre_rst_level", {27'd0, level}, 32'd7);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        chk("arst_dout", {24'd0, data_out}, 32'd0);
        chk("arst_dv", {31'd0, data_out_valid}, 32'd0);
        chk("arst_level", {27'd0, level}, 32'd0);
        chk("arst_ready", {31'd0, in_ready}, 32'd0);
        step();
        rst = 1'b0;
        step();
        chk("post_rst_dv", {31'd0, data_out_valid}, 32'd0);
        chk("post_rst_ready", {31'd0, in_ready}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
